// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: register byte offsets and default sizing, also used by
// the SoC address decoder.
package gpio_pkg;

    localparam int unsigned DEFAULT_NUM_PINS = 48;
    localparam int unsigned DEFAULT_XLEN     = 32;

    localparam logic [5:0] GPIO_IN_LO  = 6'h00;
    localparam logic [5:0] GPIO_IN_HI  = 6'h04;
    localparam logic [5:0] GPIO_OUT_LO = 6'h08;
    localparam logic [5:0] GPIO_OUT_HI = 6'h0C;
    localparam logic [5:0] GPIO_DIR_LO = 6'h10;
    localparam logic [5:0] GPIO_DIR_HI = 6'h14;
    localparam logic [5:0] GPIO_IE_LO  = 6'h18;
    localparam logic [5:0] GPIO_IE_HI  = 6'h1C;
    localparam logic [5:0] GPIO_IP_LO  = 6'h20;
    localparam logic [5:0] GPIO_IP_HI  = 6'h24;

endpackage

// File: rtl/sync_edge.sv
// Two-flop input synchronizer followed by a history flop for rising-edge detection.
module sync_edge
    import gpio_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] level_o,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] s1_q, s2_q, prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign level_o = s2_q;
    assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction/output, synchronized inputs and
// latched rising-edge interrupt flags with a registered level interrupt.
module gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int unsigned NUM_PINS = DEFAULT_NUM_PINS,
    parameter int unsigned XLEN     = DEFAULT_XLEN
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [5:0]          addr_i,
    input  logic                wr_en_i,
    input  logic [XLEN/8-1:0]   wstrb_i,
    input  logic [XLEN-1:0]     wdata_i,
    input  logic                rd_en_i,
    output logic [XLEN-1:0]     rdata_o,
    output logic                rvalid_o,
    output logic                irq_o,
    inout  wire  [NUM_PINS-1:0] io_pins_io
);

    logic [NUM_PINS-1:0] out_q, out_d;
    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] ie_q, ie_d;
    logic [NUM_PINS-1:0] ip_q, ip_d;
    logic [NUM_PINS-1:0] ip_clr;
    logic [NUM_PINS-1:0] pin_level, pin_rise;
    logic [NUM_PINS-1:0] wr_mask, wr_data;
    logic [31:0]         strb_mask, rd_word;
    logic [63:0]         rd_src;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                rvalid_q, irq_q;

    sync_edge #(
        .Width (NUM_PINS)
    ) u_sync_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (io_pins_io),
        .level_o (pin_level),
        .rise_o  (pin_rise)
    );

    // Write path: byte strobes are placed on the LO or HI half of the pin vector.
    always_comb begin
        strb_mask = {{8{wstrb_i[3]}}, {8{wstrb_i[2]}}, {8{wstrb_i[1]}}, {8{wstrb_i[0]}}};
        wr_mask   = NUM_PINS'(addr_i[2] ? {strb_mask, 32'h0} : {32'h0, strb_mask});
        wr_data   = NUM_PINS'({wdata_i[31:0], wdata_i[31:0]});
        out_d     = out_q;
        dir_d     = dir_q;
        ie_d      = ie_q;
        ip_clr    = '0;
        if (wr_en_i) begin
            case (addr_i)
                GPIO_OUT_LO, GPIO_OUT_HI: out_d  = (out_q & ~wr_mask) | (wr_data & wr_mask);
                GPIO_DIR_LO, GPIO_DIR_HI: dir_d  = (dir_q & ~wr_mask) | (wr_data & wr_mask);
                GPIO_IE_LO,  GPIO_IE_HI:  ie_d   = (ie_q & ~wr_mask) | (wr_data & wr_mask);
                GPIO_IP_LO,  GPIO_IP_HI:  ip_clr = wr_data & wr_mask;
                default: ;
            endcase
        end
        // A new edge beats a simultaneous write-1-to-clear.
        ip_d = (ip_q & ~ip_clr) | pin_rise;
    end

    // Read path: misaligned and unmapped addresses fall through to zero.
    always_comb begin
        rd_src = '0;
        case (addr_i)
            GPIO_IN_LO,  GPIO_IN_HI:  rd_src = 64'(pin_level);
            GPIO_OUT_LO, GPIO_OUT_HI: rd_src = 64'(out_q);
            GPIO_DIR_LO, GPIO_DIR_HI: rd_src = 64'(dir_q);
            GPIO_IE_LO,  GPIO_IE_HI:  rd_src = 64'(ie_q);
            GPIO_IP_LO,  GPIO_IP_HI:  rd_src = 64'(ip_q);
            default: ;
        endcase
        rd_word = addr_i[2] ? rd_src[63:32] : rd_src[31:0];
        rdata_d = rdata_q;
        if (rd_en_i) begin
            rdata_d = XLEN'(rd_word);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_q    <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            ip_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            ie_q     <= ie_d;
            ip_q     <= ip_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en_i;
            irq_q    <= |(ip_q & ie_q);
        end
    end

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pad
        assign io_pins_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign irq_o    = irq_q;

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Memory-mapped 48-pin GPIO controller that owns the SoC's `io_pins` bus. It drives or releases each pin per a direction register and synchronizes the pin inputs. It latches rising-edge interrupt flags and raises a level interrupt to the core. It sits between the core's data-bus decoder and the top-level `io_pins[47:0]` port of the SoC.

## Interface
- `NUM_PINS`, 48, number of GPIO pins (33..64); bank HI holds pins 32..NUM_PINS-1
- `XLEN`, 32, bus data width
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `addr`  in  6  byte address within the block
- `wr_en`  in  1  write strobe, one-cycle
- `wstrb`  in  4  byte enables for writes
- `wdata`  in  XLEN  write data
- `rd_en`  in  1  read strobe, one-cycle
- `rdata`  out  XLEN  registered read data
- `rvalid`  out  1  rdata valid, exactly one cycle after `rd_en`
- `irq`  out  1  level interrupt, `|(IP & IE)`, registered
- `io_pins`  inout  NUM_PINS  pad bus; pin i driven with OUT[i] when DIR[i]=1, else `'z`

## Operation
- Register map, word-aligned, LO = pins 0..31, HI = pins 32..NUM_PINS-1 (unused HI bits read 0, writes ignored):
  - 0x00 IN_LO, 0x04 IN_HI: RO, synchronized pin level
  - 0x08 OUT_LO, 0x0C OUT_HI: RW output value
  - 0x10 DIR_LO, 0x14 DIR_HI: RW, 1 = output
  - 0x18 IE_LO, 0x1C IE_HI: RW interrupt enable
  - 0x20 IP_LO, 0x24 IP_HI: interrupt pending, write-1-to-clear
- Writes: bytes with `wstrb[b]`=1 update; writes to RO or unmapped addresses are ignored.
- Misaligned `addr[1:0]`≠0: write ignored; read returns 0 with `rvalid`.
- Reads: unmapped address returns 0 with `rvalid`.
- Input path: 2-flop synchronizer (s1→s2), then prev flop.
  - IN = s2.
  - Rising edge = s2 & ~prev; it sets IP[i] regardless of IE[i].
- Output pins read back through the synchronizer; IN reflects the driven value.
- Simultaneous W1C and new edge on the same bit: set wins, IP stays 1.
- Simultaneous `rd_en` and `wr_en` to the same register: read returns the pre-write value.

## Timing
- Reset values: OUT=0, DIR=0 (all pins hi-Z), IE=0, IP=0, s1/s2/prev=0, `rdata`=0, `rvalid`=0, `irq`=0.
- Reset asserted mid-operation clears all state on the next edge. A read in flight during reset yields `rvalid`=0.
- Write takes effect at the edge sampling `wr_en`; pin drive changes in the same cycle after that edge.
- Read latency is 1: `rdata`/`rvalid` are valid the cycle after `rd_en`. `rvalid`=0 otherwise; `rdata` holds its last value.
- Pin input timeline: pin rises before edge k.
  - Edge k: s1=1.
  - Edge k+1: s2=1; IN reads 1.
  - Edge k+2: IP set, prev=1.
  - Edge k+3: `irq`=1 if IE set.
- `irq` deasserts one cycle after the W1C or IE clear edge.
- A pin held high sets IP only once; a new rising edge after W1C sets it again.
- Pulses shorter than one clock may be missed; this is not an error.

## Structure
- `gpio_pkg`: register offset localparams (`GPIO_IN_LO` … `GPIO_IP_HI`) and `NUM_PINS` default. The SoC address decoder uses the same package.
- Sub-module `sync_edge`, parameterized by width:
  - contains the s1/s2/prev flops
  - outputs `level` and `rise`
- Register file, bus logic and tri-state assigns stay in `gpio_ctrl`.

## Test plan
- Reset, then read every register.
  - Expect all 0 with `rvalid` one cycle after each `rd_en`.
  - Expect `io_pins` all z.
- Write DIR_LO=0x0000_00FF and OUT_LO=0x0000_00A5.
  - Expect `io_pins[7:0]`=0xA5, pins 8..47 z.
  - Expect IN_LO[7:0]=0xA5 read back 2 cycles after the write.
- Write OUT_HI=0xFFFF_FFFF with `wstrb`=0b0001 and DIR_HI=0xFFFF.
  - Expect `io_pins[39:32]`=0xFF and `io_pins[47:40]`=0x00.
  - Expect OUT_HI to read 0x0000_00FF.
- IE_HI bit 15 set; TB drives pin 47 0→1.
  - Expect IP_HI=0x8000 at edge k+2 and `irq`=1 at edge k+3.
  - Write IP_HI=0x8000: `irq`=0 next cycle; it must not re-set while the pin stays high.
- W1C of IP_LO bit 3 in the same cycle as a new rising edge on pin 3: IP_LO bit 3 remains 1.
- Assert `rst` for one cycle while DIR/OUT/IP are nonzero and a read is pending.
  - Expect all registers 0, `rvalid`=0, pins z on the next cycle.
